// File: rtl/mutex_lock_server_if.sv
// mutex_lock_server_if
//   Client/server bundle for the mutex lock server.
//   master : client side (drives req, rel, stall; observes lock status)
//   slave  : server side (observes requests; drives lock status)
//   Signals:
//     req[NPROC]    level request per process
//     rel[NPROC]    single-cycle release pulse per process
//     stall         inhibits new grants
//     grant[NPROC]  one-hot-or-zero grant
//     owner[IDW]    current/last grantee index
//     busy          lock granted or recovering
//     turn[IDW]     round-robin priority pointer
//     timeout       one-cycle forced-revoke pulse
//     err           sticky protocol-error flag
interface mutex_lock_server_if #(
  parameter int NPROC = 2,
  parameter int IDW   = 1
);
  logic [NPROC-1:0] req;
  logic [NPROC-1:0] rel;
  logic             stall;
  logic [NPROC-1:0] grant;
  logic [IDW-1:0]   owner;
  logic             busy;
  logic [IDW-1:0]   turn;
  logic             timeout;
  logic             err;

  modport master (
    output req, rel, stall,
    input  grant, owner, busy, turn, timeout, err
  );

  modport slave (
    input  req, rel, stall,
    output grant, owner, busy, turn, timeout, err
  );
endinterface

// File: rtl/mutex_lock_server.sv
// mutex_lock_server
//   Resource-side lock server for up to NPROC client processes. Grants a
//   single shared lock round-robin starting at the turn pointer, takes it
//   back on rel[owner] or after HOLD_MAX held cycles, and inserts one dead
//   RECOVER cycle after every release before the next grant.
//   Ports:
//     clock    posedge clock
//     reset_n  asynchronous active-low reset
//     bus      mutex_lock_server_if.slave (req/rel/stall in, status out)
module mutex_lock_server #(
  parameter int NPROC    = 2,
  parameter int IDW      = 1,
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input logic              clock,
  input logic              reset_n,
  mutex_lock_server_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [CW-1:0]  CNT_MAX   = '1;
  // Counter value seen at the edge that ends the HOLD_MAX-th held cycle.
  localparam logic [CW-1:0]  REVOKE_AT = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);
  localparam logic [IDW:0]   NPROC_W   = (IDW + 1)'(NPROC);
  localparam logic [NPROC-1:0] ONE     = NPROC'(1);

  state_t           state_q, state_d;
  logic [NPROC-1:0] grant_q, grant_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   turn_q,  turn_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             timeout_q, timeout_d;
  logic             err_q,   err_d;

  // (base + off) mod NPROC; base < NPROC and off < NPROC, so one
  // conditional subtract suffices and turn never reaches NPROC.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input logic [IDW:0]   off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NPROC_W) sum = sum - NPROC_W;
    return sum[IDW-1:0];
  endfunction

  // Round-robin pick: rotate req so bit 0 is the process at turn, then
  // take the lowest set bit as the offset from turn.
  logic [2*NPROC-1:0] req_dbl;
  logic [NPROC-1:0]   req_rot;
  logic [IDW:0]       pick_off;
  logic               pick_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    pick_off   = '0;
    req_dbl    = {bus.req, bus.req};
    req_rot    = req_dbl[turn_q +: NPROC];
    pick_valid = |req_rot;
    for (int k = NPROC - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = (IDW + 1)'(k);
    end
  end

  // Release qualification. Any rel bit other than the current holder's,
  // or more than one bit at once, is a protocol error but otherwise ignored.
  logic [NPROC-1:0] held_mask;
  logic             rel_valid, rel_stray, rel_multi, revoke;

  always_comb begin
    held_mask = (state_q == HELD) ? (ONE << owner_q) : '0;
    rel_valid = |(bus.rel & held_mask);
    rel_stray = |(bus.rel & ~held_mask);
    rel_multi = |(bus.rel & (bus.rel - ONE));
    revoke    = (HOLD_MAX != 0) && (cnt_q == REVOKE_AT);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    turn_d    = turn_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    err_d     = err_q | rel_stray | rel_multi;

    unique case (state_q)
      IDLE: begin
        if (!bus.stall && pick_valid) begin
          state_d = HELD;
          owner_d = wrap_add(turn_q, pick_off);
          grant_d = ONE << owner_d;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      HELD: begin
        // A genuine release takes priority over an expiring hold limit.
        if (rel_valid || revoke) begin
          state_d   = RECOVER;
          grant_d   = '0;
          turn_d    = wrap_add(owner_q, (IDW + 1)'(1));
          timeout_d = !rel_valid;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: every register here is control state, so all of it is reset;
  // there is no storage array that could be left unreset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      turn_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      turn_q    <= turn_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.turn    = turn_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mutex_lock_server.sv
// tb_mutex_lock_server
//   Two servers side by side: u2 (NPROC=2, HOLD_MAX=4) and u3 (NPROC=3,
//   HOLD_MAX=3). A behavioural model per instance tracks who holds the
//   lock, how long it has been held, and the round-robin turn.
module tb_mutex_lock_server;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mutex_lock_server_if #(.NPROC(2), .IDW(1)) b2 ();
  mutex_lock_server_if #(.NPROC(3), .IDW(2)) b3 ();

  mutex_lock_server #(.NPROC(2), .IDW(1), .HOLD_MAX(4), .CW(3)) u2 (
    .clock(clock), .reset_n(reset_n), .bus(b2.slave));
  mutex_lock_server #(.NPROC(3), .IDW(2), .HOLD_MAX(3), .CW(2)) u3 (
    .clock(clock), .reset_n(reset_n), .bus(b3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int n;
    int hm;
    int holder;      // -1 when nobody holds the lock
    int held;        // cycles the current grant has been visible
    bit recovering;
    int last_owner;
    int turn;
    bit timeout;
    bit err;
    int waits [8];   // grants to others while process i kept requesting
  } model_t;

  model_t m [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d].holder = -1; m[d].held = 0; m[d].recovering = 0;
      m[d].last_owner = 0; m[d].turn = 0; m[d].timeout = 0; m[d].err = 0;
      for (int i = 0; i < 8; i++) m[d].waits[i] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [7:0] req,
                            input logic [7:0] rel, input logic stall);
    int nrel = 0;
    for (int i = 0; i < m[d].n; i++) begin
      if (rel[i]) begin
        nrel++;
        if (m[d].holder != i) m[d].err = 1;
      end
    end
    if (nrel > 1) m[d].err = 1;
    m[d].timeout = 0;
    if (m[d].holder >= 0) begin
      if (rel[m[d].holder] || (m[d].hm != 0 && m[d].held == m[d].hm)) begin
        m[d].timeout    = !rel[m[d].holder];
        m[d].holder     = -1;
        m[d].recovering = 1;
        m[d].turn       = (m[d].last_owner + 1) % m[d].n;
      end else begin
        m[d].held++;
      end
    end else if (m[d].recovering) begin
      m[d].recovering = 0;
    end else if (!stall) begin
      for (int k = 0; k < m[d].n; k++) begin
        int i;
        i = (m[d].turn + k) % m[d].n;
        if (req[i]) begin
          m[d].holder = i; m[d].last_owner = i; m[d].held = 1;
          for (int j = 0; j < m[d].n; j++)
            if (j != i && req[j]) m[d].waits[j]++;
          m[d].waits[i] = 0;
          break;
        end
      end
    end
    for (int j = 0; j < m[d].n; j++) if (!req[j]) m[d].waits[j] = 0;
  endtask

  function automatic logic [7:0] exp_grant(input int d);
    return (m[d].holder >= 0) ? (8'd1 << m[d].holder) : 8'd0;
  endfunction

  function automatic logic [7:0] max_wait(input int d);
    int w = 0;
    for (int j = 0; j < m[d].n; j++) if (m[d].waits[j] > w) w = m[d].waits[j];
    return 8'(w);
  endfunction

  task automatic check_all();
    check("u2.grant",   8'(b2.grant),   exp_grant(0));
    check("u2.owner",   8'(b2.owner),   8'(m[0].last_owner));
    check("u2.busy",    8'(b2.busy),    8'(m[0].holder >= 0 || m[0].recovering));
    check("u2.turn",    8'(b2.turn),    8'(m[0].turn));
    check("u2.timeout", 8'(b2.timeout), 8'(m[0].timeout));
    check("u2.err",     8'(b2.err),     8'(m[0].err));
    check("u3.grant",   8'(b3.grant),   exp_grant(1));
    check("u3.owner",   8'(b3.owner),   8'(m[1].last_owner));
    check("u3.busy",    8'(b3.busy),    8'(m[1].holder >= 0 || m[1].recovering));
    check("u3.turn",    8'(b3.turn),    8'(m[1].turn));
    check("u3.timeout", 8'(b3.timeout), 8'(m[1].timeout));
    check("u3.err",     8'(b3.err),     8'(m[1].err));
    check("u2.onehot",  8'($onehot0(b2.grant)), 8'd1);
    check("u3.onehot",  8'($onehot0(b3.grant)), 8'd1);
    check("u2.fair",    8'(max_wait(0) <= 8'(m[0].n - 1)), 8'd1);
    check("u3.fair",    8'(max_wait(1) <= 8'(m[1].n - 1)), 8'd1);
  endtask

  // One clock edge: model steps with the inputs the DUT samples, then
  // outputs are compared 1 time unit after the edge.
  task automatic cycle();
    @(posedge clock);
    model_step(0, 8'(b2.req), 8'(b2.rel), b2.stall);
    model_step(1, 8'(b3.req), 8'(b3.rel), b3.stall);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
  task automatic mid_reset();
    #3 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    m[0].n = 2; m[0].hm = 4;
    m[1].n = 3; m[1].hm = 3;
    model_reset();
    b2.req = '0; b2.rel = '0; b2.stall = 1'b0;
    b3.req = '0; b3.rel = '0; b3.stall = 1'b0;

    // Reset state
    #11 check_all();
    check("reset.grant", 8'(b2.grant), 8'h00);
    #1 reset_n = 1'b1;

    // Basic grant/release: req at edge 1, rel at edge 4, busy drops at 5
    b2.req = 2'b01;
    cycle();
    check("t1.grant", 8'(b2.grant), 8'h01);
    b2.req = 2'b00;
    cycle(); cycle();
    b2.rel = 2'b01;
    cycle();
    check("t1.turn", 8'(b2.turn), 8'h01);
    b2.rel = 2'b00;
    cycle();
    check("t1.busy", 8'(b2.busy), 8'h00);

    // Alternating grants with both processes requesting
    b2.req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      cycle();
      check("t2.alt", 8'(b2.grant), (g % 2 == 0) ? 8'h02 : 8'h01);
      cycle();
      b2.rel = b2.grant;
      cycle();
      b2.rel = 2'b00;
      cycle();
    end
    b2.req = 2'b00;

    // Hold-time limit: grant visible exactly 4 cycles, then timeout pulse
    b2.req = 2'b01;
    cycle();
    b2.req = 2'b11;
    cycle(); cycle(); cycle();
    check("t3.held", 8'(b2.grant), 8'h01);
    cycle();
    check("t3.timeout", 8'(b2.timeout), 8'h01);
    check("t3.turn", 8'(b2.turn), 8'h01);
    cycle();
    check("t3.pulse", 8'(b2.timeout), 8'h00);
    cycle();
    check("t3.next", 8'(b2.grant), 8'h02);
    b2.req = 2'b00; b2.rel = 2'b10;
    cycle();
    b2.rel = 2'b00;
    cycle();

    // Stray release sets sticky err; grant stays with process 0
    b2.req = 2'b01;
    cycle();
    b2.req = 2'b00; b2.rel = 2'b10;
    cycle();
    check("t4.err", 8'(b2.err), 8'h01);
    check("t4.grant", 8'(b2.grant), 8'h01);
    b2.rel = 2'b00;
    cycle();
    b2.rel = 2'b01;
    cycle();
    b2.rel = 2'b00;
    cycle();
    check("t4.sticky", 8'(b2.err), 8'h01);
    mid_reset();
    check("t4.clear", 8'(b2.err), 8'h00);

    // Stall blocks new grants; then reset mid-HELD
    b2.stall = 1'b1; b2.req = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5.stall", 8'(b2.grant), 8'h00);
    end
    b2.stall = 1'b0;
    cycle();
    check("t5.first", 8'(b2.grant), 8'h01);
    b2.rel = 2'b01;
    cycle();
    b2.rel = 2'b00;
    cycle(); cycle();
    check("t5.regrant", 8'(b2.grant), 8'h02);
    check("t5.turn", 8'(b2.turn), 8'h01);
    mid_reset();
    check("t5.rgrant", 8'(b2.grant), 8'h00);
    check("t5.rturn", 8'(b2.turn), 8'h00);
    b2.req = 2'b00;

    // NPROC=3 order 0,1,2,0 with turn wrap
    b3.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      cycle();
      check("t6.order", 8'(b3.grant), 8'd1 << (g % 3));
      b3.rel = b3.grant;
      cycle();
      check("t6.turn", 8'(b3.turn), 8'((g + 1) % 3));
      b3.rel = 3'b000;
      cycle();
    end
    // Release coinciding with hold-limit expiry: no timeout
    cycle();
    cycle(); cycle();
    b3.rel = b3.grant;
    cycle();
    check("t6.coincide", 8'(b3.timeout), 8'h00);
    check("t6.dropped", 8'(b3.grant), 8'h00);
    b3.rel = 3'b000; b3.req = 3'b000;
    cycle(); cycle();

    // Randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      b2.req   = 2'($urandom);
      b3.req   = 3'($urandom);
      b2.stall = ($urandom_range(7) == 0);
      b3.stall = ($urandom_range(7) == 0);
      b2.rel   = (m[0].holder >= 0 && $urandom_range(3) == 0) ? 2'(1 << m[0].holder) : 2'b00;
      b3.rel   = (m[1].holder >= 0 && $urandom_range(3) == 0) ? 3'(1 << m[1].holder) : 3'b000;
      if (c > 300 && $urandom_range(40) == 0) b3.rel = b3.rel | 3'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
